midi_note_tx: RTL and testbench

- Serial MIDI transmitter: the outbound counterpart of the StageLights MIDI receive path.
- Accepts one complete channel-voice message (status, note, velocity) over a ready/send handshake.
- Serializes it as 8-N-1 UART frames at MIDI baud on oMIDI, LSB first, with optional running-status compression.
- Intended use: echo or generate Note-On/Note-Off traffic from the same board, e.g. MIDI-thru or test-pattern source.

---
 rtl/midi_note_tx.sv | 176 +++++++++++++++++
 tb/tb_midi_note_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_tx.sv
// Serial MIDI transmitter: sends status/note/velocity as 8-N-1 frames on oMIDI,
// optionally omitting a repeated status byte (running status).
module midi_note_tx #(
  parameter int unsigned pClocksPerBit  = 1600,
  parameter int unsigned pTimerWidth    = 11,
  parameter int unsigned pRunningStatus = 0
) (
  input  logic       gClock,
  input  logic       gReset,
  input  logic       iSend,
  input  logic [7:0] iStatus,
  input  logic [7:0] iNote,
  input  logic [7:0] iVelocity,
  output logic       oReady,
  output logic       oMIDI,
  output logic       oMsgDone,
  output logic       oError
);

  localparam logic [1:0] cIdle  = 2'd0;
  localparam logic [1:0] cStart = 2'd1;
  localparam logic [1:0] cData  = 2'd2;
  localparam logic [1:0] cStop  = 2'd3;

  localparam logic [1:0] cSelStatus   = 2'd0;
  localparam logic [1:0] cSelNote     = 2'd1;
  localparam logic [1:0] cSelVelocity = 2'd2;

  localparam logic [pTimerWidth-1:0] cLastTick = pTimerWidth'(pClocksPerBit - 1);

  logic [1:0]             state, stateNext;
  logic [pTimerWidth-1:0] bitTimer, bitTimerNext;
  logic [2:0]             bitIdx, bitIdxNext;
  logic [1:0]             byteSel, byteSelNext;
  logic [7:0]             txByte, txByteNext;
  logic [7:0]             msgNote, msgNoteNext;
  logic [7:0]             msgVelocity, msgVelocityNext;
  logic [7:0]             cacheStatus, cacheStatusNext;
  logic                   cacheValid, cacheValidNext;
  logic                   readyNext, midiNext, msgDoneNext, errorNext;
  logic                   tick, accept, skipStatus;

  // State and registered outputs
  always_ff @(posedge gClock or posedge gReset) begin
    if (gReset) begin
      state       <= cIdle;
      bitTimer    <= '0;
      bitIdx      <= '0;
      byteSel     <= cSelStatus;
      txByte      <= '0;
      msgNote     <= '0;
      msgVelocity <= '0;
      cacheStatus <= '0;
      cacheValid  <= 1'b0;
      oReady      <= 1'b1;
      oMIDI       <= 1'b1;
      oMsgDone    <= 1'b0;
      oError      <= 1'b0;
    end else begin
      state       <= stateNext;
      bitTimer    <= bitTimerNext;
      bitIdx      <= bitIdxNext;
      byteSel     <= byteSelNext;
      txByte      <= txByteNext;
      msgNote     <= msgNoteNext;
      msgVelocity <= msgVelocityNext;
      cacheStatus <= cacheStatusNext;
      cacheValid  <= cacheValidNext;
      oReady      <= readyNext;
      oMIDI       <= midiNext;
      oMsgDone    <= msgDoneNext;
      oError      <= errorNext;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext       = state;
    bitTimerNext    = bitTimer;
    bitIdxNext      = bitIdx;
    byteSelNext     = byteSel;
    txByteNext      = txByte;
    msgNoteNext     = msgNote;
    msgVelocityNext = msgVelocity;
    cacheStatusNext = cacheStatus;
    cacheValidNext  = cacheValid;
    readyNext       = oReady;
    midiNext        = oMIDI;
    errorNext       = 1'b0;
    msgDoneNext     = 1'b0;

    tick       = (bitTimer == cLastTick);
    accept     = oReady && iSend;
    skipStatus = (pRunningStatus != 0) && cacheValid && (iStatus == cacheStatus);

    case (state)
      cIdle: begin
        bitTimerNext = '0;
        midiNext     = 1'b1;
        readyNext    = 1'b1;
        if (accept) begin
          if (!iStatus[7]) begin
            errorNext = 1'b1;
          end else begin
            stateNext       = cStart;
            readyNext       = 1'b0;
            midiNext        = 1'b0;
            msgNoteNext     = iNote & 8'h7F;
            msgVelocityNext = iVelocity & 8'h7F;
            if (skipStatus) begin
              byteSelNext = cSelNote;
              txByteNext  = iNote & 8'h7F;
            end else begin
              byteSelNext = cSelStatus;
              txByteNext  = iStatus;
            end
          end
        end
      end

      cStart: begin
        bitTimerNext = tick ? '0 : bitTimer + 1'b1;
        if (tick) begin
          stateNext  = cData;
          bitIdxNext = '0;
          midiNext   = txByte[0];
        end
      end

      cData: begin
        bitTimerNext = tick ? '0 : bitTimer + 1'b1;
        if (tick) begin
          if (bitIdx == 3'd7) begin
            stateNext = cStop;
            midiNext  = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            midiNext   = txByte[bitIdx + 3'd1];
          end
        end
      end

      cStop: begin
        bitTimerNext = tick ? '0 : bitTimer + 1'b1;
        if (tick) begin
          // A status byte becomes the running-status reference once fully sent
          if (byteSel == cSelStatus) begin
            cacheStatusNext = txByte;
            cacheValidNext  = 1'b1;
          end
          if (byteSel == cSelVelocity) begin
            stateNext = cIdle;
            readyNext = 1'b1;
            midiNext  = 1'b1;
          end else begin
            stateNext   = cStart;
            midiNext    = 1'b0;
            byteSelNext = byteSel + 2'd1;
            txByteNext  = (byteSel == cSelStatus) ? msgNote : msgVelocity;
          end
        end
      end

      default: begin
        stateNext = cIdle;
        midiNext  = 1'b1;
        readyNext = 1'b1;
      end
    endcase

    // Pulse lands in the final cycle of the velocity stop bit
    msgDoneNext = (stateNext == cStop) && (bitTimerNext == cLastTick) &&
                  (byteSelNext == cSelVelocity);
  end

endmodule

// File: tb/tb_midi_note_tx.sv
// Randomized scoreboard bench for midi_note_tx: a byte-level message model feeds
// expected frames to a line monitor that checks levels, timing and handshakes.
module tb_midi_note_tx;

  localparam int unsigned cP     = 4;
  localparam int unsigned cFrame = 10 * cP;

  logic       gClock = 1'b0;
  logic       gReset = 1'b1;
  logic       iSend = 1'b0;
  logic [7:0] iStatus = 8'h00;
  logic [7:0] iNote = 8'h00;
  logic [7:0] iVelocity = 8'h00;
  logic       oReady, oMIDI, oMsgDone, oError;

  midi_note_tx #(
    .pClocksPerBit (cP),
    .pTimerWidth   (3),
    .pRunningStatus(1)
  ) dut (
    .gClock   (gClock),
    .gReset   (gReset),
    .iSend    (iSend),
    .iStatus  (iStatus),
    .iNote    (iNote),
    .iVelocity(iVelocity),
    .oReady   (oReady),
    .oMIDI    (oMIDI),
    .oMsgDone (oMsgDone),
    .oError   (oError)
  );

  always #5 gClock = ~gClock;

  typedef struct {
    logic [7:0] b;
    bit         first;
    bit         last;
    bit         gap;
    int         startAt;
  } frame_t;

  frame_t     expQ[$];
  frame_t     cur;
  int         vectors = 0;
  int         miscompares = 0;
  int         negCount = 0;
  int         stimTimeouts = 0;
  int         seenTimeouts = 0;
  bit         inFrame = 1'b0;
  int         cyc = 0;
  int         framePos = 0;
  int         idleCnt = 0;
  int         badLevels = 0;
  int         flagBad = 0;
  logic [7:0] rx = 8'h00;
  bit         errExp = 1'b0;
  bit         cacheValid = 1'b0;
  logic [7:0] cacheSt = 8'h00;
  logic [7:0] lastSt = 8'h90;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sampleFrame();
    int   bitNo;
    logic lvl;
    bitNo = cyc / cP;
    if (bitNo == 0)      lvl = 1'b0;
    else if (bitNo == 9) lvl = 1'b1;
    else                 lvl = cur.b[bitNo-1];
    if (oMIDI !== lvl) badLevels++;
    if (bitNo >= 1 && bitNo <= 8 && (cyc % cP) == cP / 2) rx[bitNo-1] = oMIDI;
    if (oReady !== 1'b0 || oError !== 1'b0 ||
        oMsgDone !== (cur.last && cyc == cFrame - 1)) flagBad++;
    if (cyc == cFrame - 1) begin
      check("frame byte", 32'(rx), 32'(cur.b));
      check("frame bit timing errors", badLevels, 0);
      check("frame handshake errors", flagBad, 0);
      inFrame = 1'b0;
      idleCnt = 0;
    end
  endtask

  // Line monitor: pops an expected frame at each start bit
  always @(negedge gClock) begin
    negCount++;
    if (stimTimeouts != seenTimeouts) begin
      check("stimulus wait bound", stimTimeouts - seenTimeouts, 0);
      seenTimeouts = stimTimeouts;
    end
    if (gReset) begin
      check("reset oMIDI", 32'(oMIDI), 1);
      check("reset oReady", 32'(oReady), 1);
      check("reset oMsgDone", 32'(oMsgDone), 0);
      check("reset oError", 32'(oError), 0);
      inFrame = 1'b0;
      expQ.delete();
      idleCnt = 0;
    end else if (!inFrame) begin
      if (oMIDI !== 1'b0 || expQ.size() == 0) begin
        check("idle oMIDI", 32'(oMIDI), 1);
        check("idle oReady", 32'(oReady), 1);
        check("idle oMsgDone", 32'(oMsgDone), 0);
        check("oError", 32'(oError), 32'(errExp));
        idleCnt++;
      end else begin
        cur = expQ.pop_front();
        framePos = cur.first ? 0 : framePos + 1;
        if (cur.startAt >= 0) check("start latency", negCount, cur.startAt);
        if (cur.gap) check("inter-message idle cycles", idleCnt, 1);
        inFrame   = 1'b1;
        cyc       = 0;
        badLevels = 0;
        flagBad   = 0;
        rx        = 8'h00;
        sampleFrame();
      end
    end else begin
      cyc++;
      sampleFrame();
    end
  end

  task automatic tick1();
    @(posedge gClock);
    #1;
  endtask

  // Reference model: byte list of one accepted message (running status enabled)
  task automatic pushMsg(input logic [7:0] st, input logic [7:0] n, input logic [7:0] v,
                         input int startAt, input bit gap);
    frame_t     f;
    logic [7:0] bl[$];
    if (!(cacheValid && st == cacheSt)) bl.push_back(st);
    bl.push_back(n & 8'h7F);
    bl.push_back(v & 8'h7F);
    foreach (bl[i]) begin
      f.b       = bl[i];
      f.first   = (i == 0);
      f.last    = (i == bl.size() - 1);
      f.gap     = gap && (i == 0);
      f.startAt = (i == 0) ? startAt : -1;
      expQ.push_back(f);
    end
    cacheValid = 1'b1;
    cacheSt    = st;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || inFrame) && n < 1000) begin
      tick1();
      n++;
    end
    if (n >= 1000) stimTimeouts++;
  endtask

  task automatic sendMsg(input logic [7:0] st, input logic [7:0] n, input logic [7:0] v);
    waitIdle();
    iStatus = st; iNote = n; iVelocity = v; iSend = 1'b1;
    if (st[7]) pushMsg(st, n, v, negCount + 2, 1'b0);
    tick1();
    iSend = 1'b0;
    {iStatus, iNote, iVelocity} = 24'($urandom);
    if (!st[7]) begin
      errExp = 1'b1;
      tick1();
      errExp = 1'b0;
    end
  endtask

  // iSend pulse while a message is in flight must be dropped
  task automatic pulseBusy();
    int n = 0;
    while (!(inFrame && expQ.size() != 0) && n < 200) begin
      tick1();
      n++;
    end
    if (n >= 200) stimTimeouts++;
    iStatus = {1'b1, 7'($urandom)}; iNote = 8'($urandom); iVelocity = 8'($urandom);
    iSend = 1'b1;
    tick1();
    iSend = 1'b0;
  endtask

  task automatic holdSend(input logic [7:0] st, input logic [7:0] n, input logic [7:0] v,
                          input int k);
    int w = 0;
    waitIdle();
    iStatus = st; iNote = n; iVelocity = v; iSend = 1'b1;
    pushMsg(st, n, v, negCount + 2, 1'b0);
    for (int i = 1; i < k; i++) pushMsg(st, n, v, -1, 1'b1);
    while (!(expQ.size() == 0 && inFrame) && w < 1000) begin
      tick1();
      w++;
    end
    if (w >= 1000) stimTimeouts++;
    iSend = 1'b0;
  endtask

  task automatic resetMid();
    int n = 0;
    while (!(inFrame && framePos == 1 && cyc >= int'(cP) + 2) && n < 400) begin
      tick1();
      n++;
    end
    if (n >= 400) stimTimeouts++;
    #2 gReset = 1'b1;
    repeat (10) @(posedge gClock);
    #2 gReset = 1'b0;
    cacheValid = 1'b0;
    tick1();
  endtask

  initial begin
    logic [7:0] st;
    int         r;
    repeat (3) tick1();
    @(posedge gClock);
    #2 gReset = 1'b0;
    tick1();

    sendMsg(8'h90, 8'h3C, 8'h64);
    sendMsg(8'h90, 8'h3E, 8'h00);
    sendMsg(8'h80, 8'h3C, 8'h00);
    sendMsg(8'h3C, 8'h10, 8'h20);
    sendMsg(8'h90, 8'hBC, 8'hFF);
    pulseBusy();
    holdSend(8'h90, 8'h3C, 8'h64, 3);
    sendMsg(8'h92, 8'h3C, 8'h64);
    resetMid();
    sendMsg(8'h90, 8'h3C, 8'h64);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)     st = {1'b0, 7'($urandom)};
      else if (r < 6) st = lastSt;
      else            st = {1'b1, 7'($urandom)};
      if (st[7]) lastSt = st;
      if ($urandom_range(0, 14) == 0 && st[7]) begin
        holdSend(st, 8'($urandom), 8'($urandom), 2);
      end else begin
        sendMsg(st, 8'($urandom), 8'($urandom));
        if (st[7] && $urandom_range(0, 3) == 0) pulseBusy();
      end
      if (i == 20) resetMid();
    end

    waitIdle();
    repeat (3) tick1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
